pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 8: width of the control bundle (ALUOp, ALUSrc, RegWrite, MemWrite, MemRead, Mem2Reg, Branch, ...).
REQ-002 Parameter DATA_W, default 128: width of the data bundle (RS/RT data, imm, funct, register addresses, pc).
REQ-003 Parameter CNT_W, default 8: width of the stall counter.
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 valid_i  input  1  upstream stage presents a valid instruction.
REQ-007 ready_o  output  1  stage can accept an instruction this cycle.
REQ-008 ctrl_i  input  CTRL_W  upstream control bundle.
REQ-009 data_i  input  DATA_W  upstream data bundle.
REQ-010 flush_i  input  1  kill all held instructions (branch taken or exception).
REQ-011 valid_o  output  1  downstream holds a valid instruction.
REQ-012 ready_i  input  1  downstream stage accepts this cycle.
REQ-013 ctrl_o  output  CTRL_W  held control bundle, gated to zero when invalid.
REQ-014 data_o  output  DATA_W  held data bundle, never gated.
REQ-015 stall_cnt_o  output  CNT_W  consecutive back-pressure cycles on the current output instruction.

Function
REQ-016 accept = valid_i & ready_o; drain = valid_o & ready_i.
REQ-017 Storage: main entry (drives outputs) plus one skid entry; occupancy states EMPTY, ONE, TWO.
REQ-018 EMPTY: on accept go to ONE and load main; otherwise hold.
REQ-019 ONE: accept & drain -> ONE, main loads input; accept only -> TWO, skid loads input; drain only -> EMPTY; neither -> hold.
REQ-020 TWO: on drain go to ONE and main loads skid; otherwise hold; no accept is possible in TWO.
REQ-021 ready_o is a registered output: 1 in EMPTY and ONE, 0 in TWO; it has no combinational path from ready_i.
REQ-022 valid_o = 1 in ONE and TWO, else 0.
REQ-023 Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 when the stage was EMPTY, or ONE with drain.
REQ-024 Ordering: instructions leave the stage in acceptance order; there is no loss and no duplication.
REQ-025 ctrl_o = main ctrl when valid_o = 1, otherwise all zeros (bubble: no RegWrite, MemWrite or Branch).
REQ-026 flush_i has highest priority: the next state is EMPTY regardless of accept/drain, and the input accepted in the same cycle is discarded.
REQ-027 After a flush, ready_o = 1 in the next cycle and no instruction from before the flush may appear on the outputs.
REQ-028 stall_cnt_o increments each cycle valid_o & !ready_i, saturating at 2^CNT_W-1 with no wrap-around.
REQ-029 stall_cnt_o clears to 0 on drain, on flush, and in EMPTY; when drain and stall coincide, the clear wins.

Reset
REQ-030 While rst_i is high, and immediately on its assertion: state EMPTY, valid_o=0, ready_o=1, ctrl_o=0, data_o=0, stall_cnt_o=0, skid entry=0.
REQ-031 Reset asserted mid-operation discards both entries with no partial update.
REQ-032 Normal operation starts on the first rising edge after rst_i deasserts.

Structure
REQ-033 The shared package pipe_pkg holds the occupancy-state enum (EMPTY, ONE, TWO) and the default CTRL_W, DATA_W and CNT_W constants.
REQ-034 The saturating counter is a sub-module, pipe_sat_cnt (parameter W; inputs inc and clr; clr dominant).
REQ-035 The block is reused for IF/ID, ID/EX, EX/MEM and MEM/WB with per-stage parameters.

Verification
REQ-036 Reset, then one push of ctrl=0x5A, data=0x1234 with ready_i=1: the instruction appears the next cycle with valid_o=1 and ctrl_o=0x5A; the cycle after, valid_o=0 and ctrl_o=0.
REQ-037 ready_i=0 and three consecutive pushes A, B, C: A is held, B goes into skid, ready_o falls after B and C is not accepted; raising ready_i drains A then B in order.
REQ-038 Stage in TWO with flush_i=1 and valid_i=1 in the same cycle: next cycle is EMPTY, valid_o=0, ctrl_o=0, ready_o=1, stall_cnt_o=0, and the input is discarded.
REQ-039 CNT_W=3 with ready_i=0 for 10 cycles while holding: stall_cnt_o counts 1..7, stays at 7, and returns to 0 on the drain cycle.
REQ-040 Random valid_i/ready_i at 50% over 10,000 cycles: the scoreboard confirms exact in-order delivery and that ready_o never depends combinationally on ready_i.
REQ-041 rst_i asserted asynchronously in state TWO, between clock edges: outputs go to their reset values before the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy states and default widths.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between pipeline stages (control + data payload).
interface pipe_stage_reg_if #(
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W_DEF,
  parameter int unsigned DATA_W = pipe_pkg::DATA_W_DEF
);

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with dominant synchronous clear.
module pipe_sat_cnt #(
  parameter int unsigned W = pipe_pkg::CNT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with registered ready, flush and stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  occ_e              state_q, state_d;
  logic              valid_q, ready_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;

  logic accept, drain;
  logic load_main_in, load_main_skid, load_skid;

  assign accept = up.valid & ready_q;
  assign drain  = valid_q & dn.ready;

  // Occupancy next-state and entry load selection; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Handshake flags are decoded from the next state so they leave flops directly.
  // Main ctrl is zeroed whenever the stage empties, giving a bubble on ctrl_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != TWO);
      if (load_main_in) begin
        main_ctrl_q <= up.ctrl;
        main_data_q <= up.data;
      end else if (load_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end
      if (state_d == EMPTY) begin
        main_ctrl_q <= '0;
      end
      if (load_skid) begin
        skid_ctrl_q <= up.ctrl;
        skid_data_q <= up.data;
      end
    end
  end

  pipe_sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (valid_q & ~dn.ready),
    .clr   (drain | flush_i | ~valid_q),
    .cnt_o (stall_cnt_o)
  );

  assign up.ready = ready_q;
  assign dn.valid = valid_q;
  assign dn.ctrl  = main_ctrl_q;
  assign dn.data  = main_data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard checks for pipe_stage_reg (default widths plus a CNT_W=3 twin).
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [7:0]   c;
    logic [127:0] d;
  } item_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_i;
  logic [7:0] cnt0;
  logic [2:0] cnt1;
  int         n_vec  = 0;
  int         n_miss = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(128)) up0 ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(128)) dn0 ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(128)) up1 ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(128)) dn1 ();

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .CNT_W(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .up          (up0),
    .dn          (dn0),
    .stall_cnt_o (cnt0)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .CNT_W(3)) dut_c3 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .up          (up1),
    .dn          (dn1),
    .stall_cnt_o (cnt1)
  );

  assign up1.valid = up0.valid;
  assign up1.ctrl  = up0.ctrl;
  assign up1.data  = up0.data;
  assign dn1.ready = dn0.ready;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [127:0] d, input logic r);
    up0.valid = v;
    up0.ctrl  = c;
    up0.data  = d;
    dn0.ready = r;
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    flush_i = 1'b0;
    drive(1'b0, 8'h00, 128'h0, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    n_vec++; if (dn0.valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid: got %b expected 0", dn0.valid); end
    n_vec++; if (up0.ready !== 1'b1) begin n_miss++; $display("FAIL reset_ready: got %b expected 1", up0.ready); end
    n_vec++; if (dn0.ctrl !== 8'h00) begin n_miss++; $display("FAIL reset_ctrl: got %h expected 00", dn0.ctrl); end
    n_vec++; if (dn0.data !== 128'h0) begin n_miss++; $display("FAIL reset_data: got %h expected 0", dn0.data); end
    n_vec++; if (cnt0 !== 8'h00) begin n_miss++; $display("FAIL reset_stall: got %h expected 00", cnt0); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_single();
    drive(1'b1, 8'h5A, 128'h1234, 1'b1);
    step();
    drive(1'b0, 8'h00, 128'h0, 1'b1);
    n_vec++; if (dn0.valid !== 1'b1) begin n_miss++; $display("FAIL single_valid: got %b expected 1", dn0.valid); end
    n_vec++; if (dn0.ctrl !== 8'h5A) begin n_miss++; $display("FAIL single_ctrl: got %h expected 5a", dn0.ctrl); end
    n_vec++; if (dn0.data !== 128'h1234) begin n_miss++; $display("FAIL single_data: got %h expected 1234", dn0.data); end
    step();
    n_vec++; if (dn0.valid !== 1'b0) begin n_miss++; $display("FAIL single_bubble_valid: got %b expected 0", dn0.valid); end
    n_vec++; if (dn0.ctrl !== 8'h00) begin n_miss++; $display("FAIL single_bubble_ctrl: got %h expected 00", dn0.ctrl); end
  endtask

  task automatic test_skid();
    drive(1'b1, 8'hA1, 128'hAAAA, 1'b0);
    step();
    n_vec++; if (up0.ready !== 1'b1) begin n_miss++; $display("FAIL skid_ready_a: got %b expected 1", up0.ready); end
    drive(1'b1, 8'hB2, 128'hBBBB, 1'b0);
    step();
    n_vec++; if (up0.ready !== 1'b0) begin n_miss++; $display("FAIL skid_ready_b: got %b expected 0", up0.ready); end
    n_vec++; if (cnt0 !== 8'd1) begin n_miss++; $display("FAIL skid_stall: got %0d expected 1", cnt0); end
    drive(1'b1, 8'hC3, 128'hCCCC, 1'b0);
    step();
    n_vec++; if (dn0.data !== 128'hAAAA) begin n_miss++; $display("FAIL skid_hold_a: got %h expected aaaa", dn0.data); end
    n_vec++; if (dn0.ctrl !== 8'hA1) begin n_miss++; $display("FAIL skid_hold_ctrl: got %h expected a1", dn0.ctrl); end
    drive(1'b0, 8'h00, 128'h0, 1'b1);
    step();
    n_vec++; if (dn0.data !== 128'hBBBB) begin n_miss++; $display("FAIL skid_drain_b: got %h expected bbbb", dn0.data); end
    n_vec++; if (dn0.ctrl !== 8'hB2) begin n_miss++; $display("FAIL skid_drain_b_ctrl: got %h expected b2", dn0.ctrl); end
    n_vec++; if (up0.ready !== 1'b1) begin n_miss++; $display("FAIL skid_ready_back: got %b expected 1", up0.ready); end
    n_vec++; if (cnt0 !== 8'd0) begin n_miss++; $display("FAIL skid_stall_clr: got %0d expected 0", cnt0); end
    step();
    n_vec++; if (dn0.valid !== 1'b0) begin n_miss++; $display("FAIL skid_empty: got %b expected 0", dn0.valid); end
    step();
    n_vec++; if (dn0.valid !== 1'b0) begin n_miss++; $display("FAIL skid_no_c: got %b expected 0", dn0.valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 8'h11, 128'h1111, 1'b0);
    step();
    drive(1'b1, 8'h22, 128'h2222, 1'b0);
    step();
    n_vec++; if (up0.ready !== 1'b0) begin n_miss++; $display("FAIL flush_pre_full: got %b expected 0", up0.ready); end
    drive(1'b1, 8'h33, 128'h3333, 1'b0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    drive(1'b0, 8'h00, 128'h0, 1'b1);
    n_vec++; if (dn0.valid !== 1'b0) begin n_miss++; $display("FAIL flush_valid: got %b expected 0", dn0.valid); end
    n_vec++; if (dn0.ctrl !== 8'h00) begin n_miss++; $display("FAIL flush_ctrl: got %h expected 00", dn0.ctrl); end
    n_vec++; if (up0.ready !== 1'b1) begin n_miss++; $display("FAIL flush_ready: got %b expected 1", up0.ready); end
    n_vec++; if (cnt0 !== 8'd0) begin n_miss++; $display("FAIL flush_stall: got %0d expected 0", cnt0); end
    step();
    n_vec++; if (dn0.valid !== 1'b0) begin n_miss++; $display("FAIL flush_discard: got %b expected 0", dn0.valid); end
    drive(1'b1, 8'h44, 128'h4444, 1'b1);
    step();
    drive(1'b0, 8'h00, 128'h0, 1'b1);
    n_vec++; if (dn0.data !== 128'h4444) begin n_miss++; $display("FAIL flush_after_data: got %h expected 4444", dn0.data); end
    step();
  endtask

  task automatic test_stall();
    logic [2:0] exp3;
    drive(1'b1, 8'h77, 128'h7777, 1'b0);
    step();
    drive(1'b0, 8'h00, 128'h0, 1'b0);
    n_vec++; if (cnt1 !== 3'd0) begin n_miss++; $display("FAIL stall_start: got %0d expected 0", cnt1); end
    for (int k = 1; k <= 10; k++) begin
      step();
      exp3 = (k > 7) ? 3'd7 : 3'(k);
      n_vec++; if (cnt1 !== exp3) begin n_miss++; $display("FAIL stall_c3_%0d: got %0d expected %0d", k, cnt1, exp3); end
      n_vec++; if (cnt0 !== 8'(k)) begin n_miss++; $display("FAIL stall_c8_%0d: got %0d expected %0d", k, cnt0, k); end
    end
    dn0.ready = 1'b1;
    step();
    n_vec++; if (cnt1 !== 3'd0) begin n_miss++; $display("FAIL stall_drain_c3: got %0d expected 0", cnt1); end
    n_vec++; if (cnt0 !== 8'd0) begin n_miss++; $display("FAIL stall_drain_c8: got %0d expected 0", cnt0); end
    n_vec++; if (dn1.valid !== 1'b0) begin n_miss++; $display("FAIL stall_drain_valid: got %b expected 0", dn1.valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 128'(i * 16'h0101), 1'b1);
      step();
      n_vec++; if (dn0.data !== 128'(i * 16'h0101)) begin n_miss++; $display("FAIL b2b_data_%0d: got %h expected %h", i, dn0.data, 128'(i * 16'h0101)); end
      n_vec++; if (dn0.ctrl !== 8'(i)) begin n_miss++; $display("FAIL b2b_ctrl_%0d: got %h expected %h", i, dn0.ctrl, 8'(i)); end
    end
    drive(1'b0, 8'h00, 128'h0, 1'b1);
    step();
    n_vec++; if (dn0.valid !== 1'b0) begin n_miss++; $display("FAIL b2b_end: got %b expected 0", dn0.valid); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'h91, 128'h9191, 1'b0);
    step();
    drive(1'b1, 8'h92, 128'h9292, 1'b0);
    step();
    drive(1'b0, 8'h00, 128'h0, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    n_vec++; if (dn0.valid !== 1'b0) begin n_miss++; $display("FAIL areset_valid: got %b expected 0", dn0.valid); end
    n_vec++; if (up0.ready !== 1'b1) begin n_miss++; $display("FAIL areset_ready: got %b expected 1", up0.ready); end
    n_vec++; if (dn0.ctrl !== 8'h00) begin n_miss++; $display("FAIL areset_ctrl: got %h expected 00", dn0.ctrl); end
    n_vec++; if (dn0.data !== 128'h0) begin n_miss++; $display("FAIL areset_data: got %h expected 0", dn0.data); end
    n_vec++; if (cnt0 !== 8'd0) begin n_miss++; $display("FAIL areset_stall: got %0d expected 0", cnt0); end
    #2;
    rst_i = 1'b0;
    dn0.ready = 1'b1;
    step();
    n_vec++; if (dn0.valid !== 1'b0) begin n_miss++; $display("FAIL areset_skid_gone: got %b expected 0", dn0.valid); end
  endtask

  task automatic test_random();
    item_t      q[$];
    item_t      it;
    logic       v, r;
    int         sz;
    logic [7:0] stall_m;
    stall_m = 8'd0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      v    = 1'($urandom_range(0, 1));
      r    = 1'($urandom_range(0, 1));
      it.c = 8'($urandom());
      it.d = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive(v, it.c, it.d, r);
      sz = q.size();
      n_vec++; if (dn0.valid !== (sz > 0)) begin n_miss++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, dn0.valid, sz > 0); end
      n_vec++; if (up0.ready !== (sz < 2)) begin n_miss++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, up0.ready, sz < 2); end
      n_vec++; if (cnt0 !== stall_m) begin n_miss++; $display("FAIL rnd_stall@%0d: got %0d expected %0d", cyc, cnt0, stall_m); end
      if (sz == 0) begin
        n_vec++; if (dn0.ctrl !== 8'h00) begin n_miss++; $display("FAIL rnd_bubble@%0d: got %h expected 00", cyc, dn0.ctrl); end
      end else begin
        n_vec++; if (dn0.data !== q[0].d || dn0.ctrl !== q[0].c) begin n_miss++; $display("FAIL rnd_order@%0d: got %h/%h expected %h/%h", cyc, dn0.ctrl, dn0.data, q[0].c, q[0].d); end
      end
      dn0.ready = ~r;
      #1;
      n_vec++; if (up0.ready !== (sz < 2)) begin n_miss++; $display("FAIL rnd_ready_comb@%0d: got %b expected %b", cyc, up0.ready, sz < 2); end
      dn0.ready = r;
      if (sz > 0 && r) void'(q.pop_front());
      if (v && sz < 2) q.push_back(it);
      if (sz > 0 && !r) stall_m = (stall_m == 8'hFF) ? 8'hFF : stall_m + 8'd1;
      else              stall_m = 8'd0;
      step();
    end
    drive(1'b0, 8'h00, 128'h0, 1'b1);
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_skid();
    test_flush();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
